line_hit_engine: RTL and testbench



---
 rtl/line_hit_pkg.sv | 28 ++
 rtl/line_hit_engine_if.sv | 41 ++++
 rtl/seg_dist_pipe.sv | 99 +++++++++
 rtl/line_hit_engine.sv | 152 +++++++++++++++
 tb/tb_line_hit_engine.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/line_hit_pkg.sv
// Shared types and defaults for the multi-segment pixel-on-line engine.
// Segment fields are held at W_DEF width; the engine sign-extends narrower buses into them.
package line_hit_pkg;

    localparam int W_DEF    = 32;
    localparam int FRAC_DEF = 16;

    typedef struct packed {
        logic signed [W_DEF-1:0] x0;
        logic signed [W_DEF-1:0] y0;
        logic signed [W_DEF-1:0] xn;
        logic signed [W_DEF-1:0] yn;
        logic signed [W_DEF-1:0] mag;
        logic                    en;
    } seg_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        RESULT
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_hit_engine_if.sv
// Pixel, result and segment-configuration handshakes of line_hit_engine.
// The engine sits on the slave modport; the scan counter / CPU side drives the master modport.
interface line_hit_engine_if
    import line_hit_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int IDXW = 2
);
    logic                   in_valid;
    logic                   in_ready;
    logic signed [W-1:0]    in_x;
    logic signed [W-1:0]    in_y;

    logic                   out_valid;
    logic                   out_ready;
    logic                   out_hit;
    logic [IDXW-1:0]        out_idx;

    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [IDXW-1:0]        cfg_addr;
    logic signed [W-1:0]    cfg_x0;
    logic signed [W-1:0]    cfg_y0;
    logic signed [W-1:0]    cfg_xn;
    logic signed [W-1:0]    cfg_yn;
    logic signed [W-1:0]    cfg_mag;
    logic                   cfg_en;

    modport master (
        output in_valid, in_x, in_y, out_ready,
        output cfg_valid, cfg_addr, cfg_x0, cfg_y0, cfg_xn, cfg_yn, cfg_mag, cfg_en,
        input  in_ready, out_valid, out_hit, out_idx, cfg_ready
    );

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        input  cfg_valid, cfg_addr, cfg_x0, cfg_y0, cfg_xn, cfg_yn, cfg_mag, cfg_en,
        output in_ready, out_valid, out_hit, out_idx, cfg_ready
    );

endinterface

// File: rtl/seg_dist_pipe.sv
// Three-stage point-to-segment test: offsets, then projection/cross products, then compare.
// LINE_HIT_ROUND_CAP_EN adds rounded end caps without changing latency.
module seg_dist_pipe
    import line_hit_pkg::*;
#(
    parameter int W              = W_DEF,
    parameter int FRAC           = FRAC_DEF,
    parameter int LINE_WIDTH_SQR = 100,
    parameter int IDXW           = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [IDXW-1:0]     in_idx,
    input  logic signed [W-1:0] px,
    input  logic signed [W-1:0] py,
    input  seg_t                seg,
    output logic                out_valid,
    output logic                out_hit,
    output logic [IDXW-1:0]     out_idx
);
    localparam int PW = 2 * W + 2;
    localparam int SW = 2 * PW;
    localparam logic signed [SW-1:0] LIMIT = SW'(LINE_WIDTH_SQR) << (2 * FRAC);

    logic                    v1, v2;
    logic [IDXW-1:0]         idx1, idx2;
    logic signed [W:0]       dx_c, dy_c, dx1, dy1;
    logic signed [W_DEF-1:0] xn1, yn1, mag1;
    logic                    en1, en2;
    logic signed [PW-1:0]    dot_c, crs_c, t2, p2, mag2;
    logic signed [SW-1:0]    p_sq;
    logic                    in_body;
`ifdef LINE_HIT_ROUND_CAP_EN
    logic signed [SW-1:0]    dd_c, dd2, e_sq;
    logic signed [PW-1:0]    e_c;
    logic                    cap_lo, cap_hi;
`endif

    // NOTE: every always_comb assigns a default first so no latch is inferred.
    always_comb begin
        dx_c  = (W+1)'(px) - (W+1)'($signed(seg.x0));
        dy_c  = (W+1)'(py) - (W+1)'($signed(seg.y0));
        dot_c = (PW'(dx1) * PW'(xn1)) + (PW'(dy1) * PW'(yn1));
        crs_c = (PW'(dx1) * PW'(yn1)) - (PW'(dy1) * PW'(xn1));
`ifdef LINE_HIT_ROUND_CAP_EN
        dd_c  = (SW'(dx1) * SW'(dx1)) + (SW'(dy1) * SW'(dy1));
`endif
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= in_valid;
            v2 <= v1;
        end
    end

    // NOTE: datapath registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        idx1 <= in_idx;
        dx1  <= dx_c;
        dy1  <= dy_c;
        xn1  <= $signed(seg.xn);
        yn1  <= $signed(seg.yn);
        mag1 <= $signed(seg.mag);
        en1  <= seg.en;

        idx2 <= idx1;
        t2   <= dot_c >>> FRAC;
        p2   <= crs_c >>> FRAC;
        mag2 <= PW'(mag1);
        en2  <= en1;
`ifdef LINE_HIT_ROUND_CAP_EN
        dd2  <= dd_c;
`endif
    end

    // Stage 3: all squares are full width, so the compares are exact at 2*FRAC scale.
    always_comb begin
        p_sq    = SW'(p2) * SW'(p2);
        in_body = !t2[PW-1] && (t2 <= mag2) && (p_sq <= LIMIT);
`ifdef LINE_HIT_ROUND_CAP_EN
        e_c     = t2 - mag2;
        e_sq    = SW'(e_c) * SW'(e_c);
        cap_lo  = t2[PW-1] && (dd2 <= LIMIT);
        cap_hi  = (t2 > mag2) && ((e_sq + p_sq) <= LIMIT);
        out_hit = v2 && en2 && (in_body || cap_lo || cap_hi);
`else
        out_hit = v2 && en2 && in_body;
`endif
        out_valid = v2;
        out_idx   = idx2;
    end

endmodule

// File: rtl/line_hit_engine.sv
// Tests each pixel against NUM_LINES stored segments and reports the lowest covering index.
// Optional build macro LINE_HIT_ROUND_CAP_EN enables rounded segment end caps.
module line_hit_engine
    import line_hit_pkg::*;
#(
    parameter int W              = W_DEF,
    parameter int FRAC           = FRAC_DEF,
    parameter int NUM_LINES      = 4,
    parameter int LINE_WIDTH_SQR = 100
) (
    input  logic         clk,
    input  logic         rst,
    line_hit_engine_if.slave bus
);
    localparam int IDXW = idx_width(NUM_LINES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_LINES - 1);

    state_t              state;
    logic [IDXW-1:0]     scan_idx;
    logic [1:0]          drain_cnt;
    logic                in_ready_q, cfg_ready_q, out_valid_q, out_hit_q;
    logic [IDXW-1:0]     out_idx_q;
    logic                acc_hit;
    logic [IDXW-1:0]     acc_idx;

    logic signed [W-1:0] px, py;
    seg_t                tbl [NUM_LINES];
    logic [NUM_LINES-1:0] tbl_en;
    seg_t                issue_seg;
    logic                cfg_fire, accept;

    logic                pipe_valid, pipe_hit;
    logic [IDXW-1:0]     pipe_idx;

    assign accept   = (state == IDLE) && bus.in_valid;
    assign cfg_fire = bus.cfg_valid && cfg_ready_q && (int'(bus.cfg_addr) < NUM_LINES);

    assign bus.in_ready  = in_ready_q;
    assign bus.cfg_ready = cfg_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_hit   = out_hit_q;
    assign bus.out_idx   = out_idx_q;

    // tbl_en is the resettable copy of each enable; the stored en bit is gated by it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_en <= '0;
        end else if (cfg_fire) begin
            tbl_en[bus.cfg_addr] <= bus.cfg_en;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_fire) begin
            tbl[bus.cfg_addr] <= seg_t'{
                x0:  W_DEF'(bus.cfg_x0),
                y0:  W_DEF'(bus.cfg_y0),
                xn:  W_DEF'(bus.cfg_xn),
                yn:  W_DEF'(bus.cfg_yn),
                mag: W_DEF'(bus.cfg_mag),
                en:  bus.cfg_en
            };
        end
        if (accept) begin
            px <= bus.in_x;
            py <= bus.in_y;
        end
    end

    always_comb begin
        issue_seg    = tbl[scan_idx];
        issue_seg.en = tbl[scan_idx].en & tbl_en[scan_idx];
    end

    seg_dist_pipe #(
        .W              (W),
        .FRAC           (FRAC),
        .LINE_WIDTH_SQR (LINE_WIDTH_SQR),
        .IDXW           (IDXW)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (state == SCAN),
        .in_idx    (scan_idx),
        .px        (px),
        .py        (py),
        .seg       (issue_seg),
        .out_valid (pipe_valid),
        .out_hit   (pipe_hit),
        .out_idx   (pipe_idx)
    );

    // Drain spans both pipe stages plus the final accumulate, fixing latency at NUM_LINES+3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            scan_idx    <= '0;
            drain_cnt   <= '0;
            in_ready_q  <= 1'b1;
            cfg_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_idx_q   <= '0;
            acc_hit     <= 1'b0;
            acc_idx     <= '0;
        end else begin
            if (pipe_valid && pipe_hit && !acc_hit) begin
                acc_hit <= 1'b1;
                acc_idx <= pipe_idx;
            end
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state       <= SCAN;
                        scan_idx    <= '0;
                        acc_hit     <= 1'b0;
                        acc_idx     <= '0;
                        in_ready_q  <= 1'b0;
                        cfg_ready_q <= 1'b0;
                    end
                end
                SCAN: begin
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_idx == LAST_IDX) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'd2) begin
                        state       <= RESULT;
                        out_valid_q <= 1'b1;
                        out_hit_q   <= acc_hit;
                        out_idx_q   <= acc_idx;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                RESULT: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        cfg_ready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_hit_engine.sv
// Directed bench for line_hit_engine: reset, hits, priority, caps, bounds, backpressure, abort.
// Expectations follow LINE_HIT_ROUND_CAP_EN when the bench is built with that macro.
module tb_line_hit_engine;
    import line_hit_pkg::*;

    localparam int W    = 32;
    localparam int FRAC = 16;
    localparam int N    = 4;
    localparam int IDXW = 2;
    localparam int ONE  = 1 << FRAC;
    localparam int DIAG = 46341;
    localparam int LAT  = N + 3;
`ifdef LINE_HIT_ROUND_CAP_EN
    localparam logic CAP = 1'b1;
`else
    localparam logic CAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   lat;

    always #5 clk = ~clk;

    line_hit_engine_if #(.W(W), .IDXW(IDXW)) bus ();

    line_hit_engine #(
        .W              (W),
        .FRAC           (FRAC),
        .NUM_LINES      (N),
        .LINE_WIDTH_SQR (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int addr, input int x0, input int y0, input int xn,
                             input int yn, input int mag, input logic en);
        bus.cfg_addr  = addr[IDXW-1:0];
        bus.cfg_x0    = x0 * ONE;
        bus.cfg_y0    = y0 * ONE;
        bus.cfg_xn    = xn;
        bus.cfg_yn    = yn;
        bus.cfg_mag   = mag * ONE;
        bus.cfg_en    = en;
        bus.cfg_valid = 1'b1;
        @(posedge clk);
        #1 bus.cfg_valid = 1'b0;
    endtask

    task automatic accept_pixel(input int x, input int y);
        bus.in_x     = x * ONE;
        bus.in_y     = y * ONE;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic query(input string tag, input int x, input int y,
                         input logic exp_hit, input int exp_idx);
        int l;
        accept_pixel(x, y);
        wait_result(l);
        check({tag, ".lat"}, l, LAT);
        check({tag, ".hit"}, bus.out_hit, exp_hit);
        check({tag, ".idx"}, bus.out_idx, exp_idx);
        take_result();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_x0    = '0;
        bus.cfg_y0    = '0;
        bus.cfg_xn    = '0;
        bus.cfg_yn    = '0;
        bus.cfg_mag   = '0;
        bus.cfg_en    = 1'b0;

        #2 rst = 1'b1;
        #1;
        check("rst.in_ready", bus.in_ready, 1);
        check("rst.cfg_ready", bus.cfg_ready, 1);
        check("rst.out_valid", bus.out_valid, 0);
        check("rst.out_hit", bus.out_hit, 0);
        check("rst.out_idx", bus.out_idx, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        query("empty", 3, 3, 1'b0, 0);

        cfg_write(0, 0, 0, DIAG, DIAG, 30, 1'b1);
        query("diag_on", 10, 10, 1'b1, 0);
        query("diag_near", 5, 10, 1'b1, 0);

        cfg_write(0, 20, 15, 0, ONE, 10, 1'b1);
        cfg_write(1, 0, 0, DIAG, DIAG, 20, 1'b1);
        query("prio_seg1", 5, 10, 1'b1, 1);
        query("prio_seg0", 17, 17, 1'b1, 0);

        cfg_write(1, 0, 0, DIAG, DIAG, 20, 1'b0);
        cfg_write(0, 0, 0, ONE, 0, 10, 1'b1);
        query("cap_near", -6, 0, CAP, 0);
        query("cap_far", -11, 0, 1'b0, 0);
        query("t_eq_mag", 10, 0, 1'b1, 0);
        query("p_eq_lim", 5, 10, 1'b1, 0);
        query("p_over", 5, 11, 1'b0, 0);

        accept_pixel(10, 0);
        wait_result(lat);
        check("bp.lat", lat, LAT);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp.out_valid", bus.out_valid, 1);
            check("bp.out_hit", bus.out_hit, 1);
            check("bp.out_idx", bus.out_idx, 0);
            check("bp.in_ready", bus.in_ready, 0);
        end
        take_result();

        accept_pixel(3, 0);
        bus.cfg_addr  = '0;
        bus.cfg_en    = 1'b0;
        bus.cfg_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("busy.cfg_ready", bus.cfg_ready, 0);
            @(posedge clk);
            #1;
        end
        bus.cfg_valid = 1'b0;
        wait_result(lat);
        check("busy.seen", lat > 0, 1);
        check("busy.hit", bus.out_hit, 1);
        check("busy.idx", bus.out_idx, 0);
        take_result();
        query("busy_after", 3, 0, 1'b1, 0);

        accept_pixel(3, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort.in_ready", bus.in_ready, 1);
        check("abort.cfg_ready", bus.cfg_ready, 1);
        check("abort.out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        query("abort_requery", 3, 0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
